// File: rtl/coreriscv_axi4_beat_lock_arbiter_4.sv
`default_nettype none
// ============================================================================
// Module   : coreriscv_axi4_beat_lock_arbiter_4
// Brief    : 4-to-1 round-robin beat arbiter for header-routed channels.
//            The grant is locked to one input until that input's last beat
//            is accepted, and the winning beat sits in a one-entry output
//            register. Optional lock watchdog is enabled by the macro
//            CORERISCV_AXI4_BEAT_LOCK_ARB_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module coreriscv_axi4_beat_lock_arbiter_4 #(
    parameter int RESET_LAST_GRANT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_in_0_valid,
    output logic       io_in_0_ready,
    input  logic [1:0] io_in_0_bits_header_src,
    input  logic [1:0] io_in_0_bits_header_dst,
    input  logic [1:0] io_in_0_bits_payload_manager_xact_id,
    input  logic       io_in_0_bits_last,
    input  logic       io_in_1_valid,
    output logic       io_in_1_ready,
    input  logic [1:0] io_in_1_bits_header_src,
    input  logic [1:0] io_in_1_bits_header_dst,
    input  logic [1:0] io_in_1_bits_payload_manager_xact_id,
    input  logic       io_in_1_bits_last,
    input  logic       io_in_2_valid,
    output logic       io_in_2_ready,
    input  logic [1:0] io_in_2_bits_header_src,
    input  logic [1:0] io_in_2_bits_header_dst,
    input  logic [1:0] io_in_2_bits_payload_manager_xact_id,
    input  logic       io_in_2_bits_last,
    input  logic       io_in_3_valid,
    output logic       io_in_3_ready,
    input  logic [1:0] io_in_3_bits_header_src,
    input  logic [1:0] io_in_3_bits_header_dst,
    input  logic [1:0] io_in_3_bits_payload_manager_xact_id,
    input  logic       io_in_3_bits_last,
    input  logic       io_out_ready,
    output logic       io_out_valid,
    output logic [1:0] io_out_bits_header_src,
    output logic [1:0] io_out_bits_header_dst,
    output logic [1:0] io_out_bits_payload_manager_xact_id,
    output logic       io_out_bits_last,
`ifdef CORERISCV_AXI4_BEAT_LOCK_ARB_WATCHDOG_EN
    output logic [7:0] io_lock_stall_cnt,
    output logic       io_lock_stall,
`endif
    output logic [1:0] io_chosen
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;
    localparam logic [1:0] c_reset_last_grant = 2'(RESET_LAST_GRANT);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [1:0] r_last_grant;
    logic [1:0] w_last_grant_nxt;
    logic [1:0] r_lock_idx;
    logic [1:0] w_lock_idx_nxt;

    logic       r_out_valid;
    logic [1:0] r_out_src;
    logic [1:0] r_out_dst;
    logic [1:0] r_out_xact;
    logic       r_out_last;
    logic [1:0] r_chosen;

    logic [3:0] w_valid;
    logic [3:0] w_ready;
    logic [1:0] w_gnt;
    logic       w_gnt_vld;
    logic       w_can_load;
    logic       w_acc;
    logic [1:0] w_sel_src;
    logic [1:0] w_sel_dst;
    logic [1:0] w_sel_xact;
    logic       w_sel_last;

    assign w_valid    = {io_in_3_valid, io_in_2_valid, io_in_1_valid, io_in_0_valid};
    assign w_can_load = !r_out_valid || io_out_ready;

    // Grant: locked input while a message is open, otherwise round-robin scan
    // starting just after the last completed grant. Descending loop so the
    // nearest valid input (smallest offset) overrides farther ones.
    always_comb begin
        w_gnt     = 2'd0;
        w_gnt_vld = 1'b0;
        if (r_state == S_LOCKED) begin
            w_gnt     = r_lock_idx;
            w_gnt_vld = 1'b1;
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (w_valid[r_last_grant + 2'(i + 1)]) begin
                    w_gnt     = r_last_grant + 2'(i + 1);
                    w_gnt_vld = 1'b1;
                end
            end
        end
    end

    // Ready goes only to the granted input, and only when the register can take a beat.
    assign w_ready = (w_gnt_vld && w_can_load) ? (4'b0001 << w_gnt) : 4'b0000;
    assign w_acc   = w_valid[w_gnt] && w_ready[w_gnt];

    assign io_in_0_ready = w_ready[0];
    assign io_in_1_ready = w_ready[1];
    assign io_in_2_ready = w_ready[2];
    assign io_in_3_ready = w_ready[3];

    // Beat field mux for the granted input.
    always_comb begin
        w_sel_src  = io_in_0_bits_header_src;
        w_sel_dst  = io_in_0_bits_header_dst;
        w_sel_xact = io_in_0_bits_payload_manager_xact_id;
        w_sel_last = io_in_0_bits_last;
        case (w_gnt)
            2'd1: begin
                w_sel_src  = io_in_1_bits_header_src;
                w_sel_dst  = io_in_1_bits_header_dst;
                w_sel_xact = io_in_1_bits_payload_manager_xact_id;
                w_sel_last = io_in_1_bits_last;
            end
            2'd2: begin
                w_sel_src  = io_in_2_bits_header_src;
                w_sel_dst  = io_in_2_bits_header_dst;
                w_sel_xact = io_in_2_bits_payload_manager_xact_id;
                w_sel_last = io_in_2_bits_last;
            end
            2'd3: begin
                w_sel_src  = io_in_3_bits_header_src;
                w_sel_dst  = io_in_3_bits_header_dst;
                w_sel_xact = io_in_3_bits_payload_manager_xact_id;
                w_sel_last = io_in_3_bits_last;
            end
            default: ;
        endcase
    end

    // Lock FSM next state; the round-robin pointer moves only on message completion.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_lock_idx_nxt   = r_lock_idx;
        if (w_acc) begin
            if (w_sel_last) begin
                w_state_nxt      = S_IDLE;
                w_last_grant_nxt = w_gnt;
            end else if (r_state == S_IDLE) begin
                w_state_nxt    = S_LOCKED;
                w_lock_idx_nxt = w_gnt;
            end
        end
    end

    // FSM state and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_reset_last_grant;
            r_lock_idx   <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_lock_idx   <= w_lock_idx_nxt;
        end
    end

    // One-entry output register: load on accept (also when draining), clear on drain only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_src   <= 2'd0;
            r_out_dst   <= 2'd0;
            r_out_xact  <= 2'd0;
            r_out_last  <= 1'b0;
            r_chosen    <= 2'd0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_src   <= w_sel_src;
            r_out_dst   <= w_sel_dst;
            r_out_xact  <= w_sel_xact;
            r_out_last  <= w_sel_last;
            r_chosen    <= w_gnt;
        end else if (io_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_out_valid                        = r_out_valid;
    assign io_out_bits_header_src              = r_out_src;
    assign io_out_bits_header_dst              = r_out_dst;
    assign io_out_bits_payload_manager_xact_id = r_out_xact;
    assign io_out_bits_last                    = r_out_last;
    assign io_chosen                           = r_chosen;

`ifdef CORERISCV_AXI4_BEAT_LOCK_ARB_WATCHDOG_EN
    logic [7:0] r_stall_cnt;

    // Count consecutive locked cycles with the locked input idle; saturate at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 8'd0;
        end else if (r_state == S_LOCKED && !w_acc && !w_valid[r_lock_idx]) begin
            if (r_stall_cnt != 8'hFF) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end else begin
            r_stall_cnt <= 8'd0;
        end
    end

    assign io_lock_stall_cnt = r_stall_cnt;
    assign io_lock_stall     = (r_stall_cnt == 8'hFF);
`endif

endmodule
`default_nettype wire

// File: doc/coreriscv_axi4_beat_lock_arbiter_4.md
Name: coreriscv_axi4_beat_lock_arbiter_4

Overview:
- 4-input to 1-output round-robin arbiter for header-routed network channels: header src/dst plus payload manager_xact_id.
- Locks the grant to one input until that input's last beat is accepted, so multi-beat messages are never interleaved.
- Holds the winning beat in a one-entry output register before the dst-decoding bus fan-out.
- Sits between four client/manager channel sources and the basic bus output demux.

Parameters:
- RESET_LAST_GRANT, default 3: value loaded into the last-grant pointer on reset. The default gives input 0 highest priority first.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- io_in_N_valid  in  1  N=0..3; beat valid
- io_in_N_ready  out  1  N=0..3; beat accepted when valid&ready
- io_in_N_bits_header_src  in  2  source id
- io_in_N_bits_header_dst  in  2  destination id
- io_in_N_bits_payload_manager_xact_id  in  2  transaction id
- io_in_N_bits_last  in  1  final beat of message (1 for single-beat messages)
- io_out_ready  in  1  downstream ready
- io_out_valid  out  1  output register full
- io_out_bits_header_src / _header_dst / _payload_manager_xact_id  out  2 each  registered beat fields
- io_out_bits_last  out  1  registered last flag
- io_chosen  out  2  index of the input that supplied the beat in the output register

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is synchronous and active-high; ports are named clk and reset.
  - Reset values: io_out_valid=0, all io_out_bits=0, io_chosen=0, state=IDLE, last_grant=RESET_LAST_GRANT, lock_idx=0.
- Output register:
  - full = io_out_valid.
  - can_load = !full | io_out_ready.
  - An accepted input beat is loaded on the next clk edge, giving 1-cycle latency.
  - If draining and loading happen in the same cycle, the register keeps io_out_valid=1 and takes the new beat. Throughput is 1 beat/cycle.
  - Drain without load clears io_out_valid. Bits are don't-care when invalid; hold their last value.
- Grant selection in IDLE:
  - Scan inputs starting at (last_grant+1) mod 4 and wrapping; the first valid input wins (gnt).
  - No input valid means no grant.
- Grant in LOCKED: gnt = lock_idx, regardless of other valids.
- io_in_N_ready = (N==gnt) & can_load. Non-granted inputs see ready=0.
  - In LOCKED, ready is asserted to lock_idx even if its valid is low.
- State machine (2 states), with acc = io_in_gnt_valid & io_in_gnt_ready:
  - IDLE, acc & last=1: stay IDLE, last_grant<=gnt.
  - IDLE, acc & last=0: go to LOCKED, lock_idx<=gnt.
  - LOCKED, acc & last=1: go to IDLE, last_grant<=lock_idx.
  - LOCKED, no acc: hold. A bubble on the locked input keeps the lock; all others stay blocked.
- last_grant updates only on message completion, not on each beat.
- io_chosen is updated together with the data on load.
- Mid-operation reset: the lock and output register are discarded immediately and the partial message is dropped. Upstream is reset in the same cycle.
- No combinational path from io_in_*_bits to io_out_*. Path from io_out_ready to io_in_*_ready is allowed.

Optional Feature:
- Macro: CORERISCV_AXI4_BEAT_LOCK_ARB_WATCHDOG_EN.
- When defined, two extra outputs are added:
  - io_lock_stall_cnt (8 bits): saturating counter of consecutive LOCKED cycles where the locked input is not valid. Cleared on any acc, on leaving LOCKED, and on reset.
  - io_lock_stall (1 bit): set when the counter reaches 255.
  - Both reset to 0. The arbitration logic is unchanged.
- When undefined, these ports and counters are absent.

Test Plan:
- Reset, then inputs 0..3 all valid with single beats (last=1), io_out_ready=1 -> io_chosen sequence 0,1,2,3,0 on consecutive cycles. First io_out_valid=1 appears one cycle after the first acceptance.
- Input 2 sends a 3-beat message (dst=1, xact=2, last=0,0,1) while inputs 0 and 3 stay valid -> three consecutive output beats with io_chosen=2. Then grant goes to 3, then 0. Input 0/3 ready stays 0 during the lock.
- Input 1 locked; its valid drops for 4 cycles mid-message -> no output beats, io_in_0/2/3_ready=0 throughout, lock retained. Watchdog build: io_lock_stall_cnt=4.
- io_out_ready=0 with output full -> all io_in_*_ready=0 and io_out bits stable. Raise ready while input 0 is valid -> drain and load in the same cycle, io_out_valid stays 1.
- Assert reset while locked to input 3 with output full -> next cycle io_out_valid=0, state IDLE. With all inputs valid, the next grant goes to input 0 (RESET_LAST_GRANT=3).
- Watchdog build: locked input idle for 300 cycles -> counter saturates at 255 with io_lock_stall=1. Next accepted beat clears both.
